// File: rtl/memory_pkg.sv
// memory_pkg
// Shared types and helpers for the memory_clr storage block.
//   state_t     : controller state (CLEAR sweep, READY for requests)
//   LANES       : lane count for the default 8-bit word / 8-bit lane build
//   lane_merge  : per-lane select between an old and a new word
package memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int LANE_W_DEF = 8;
    localparam int LANES      = DATA_W_DEF / LANE_W_DEF;

    // lane_merge works on the widest supported word; callers zero-extend
    // their operands and truncate the result back to their own DATA_W.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_LANES  = 256;

    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_LANES-1:0]  be,
        input int                    lane_w
    );
        logic [MAX_DATA_W-1:0] v_word;
        logic [7:0]            v_lane;
        logic [7:0]            v_bit;
        v_word = old_w;
        for (int b = 0; b < MAX_DATA_W; b++) begin
            v_bit  = 8'(b);
            v_lane = 8'(b / lane_w);
            if (be[v_lane]) begin
                v_word[v_bit] = new_w[v_bit];
            end
        end
        return v_word;
    endfunction

endpackage

// File: rtl/memory_clr_sweep.sv
// memory_clr_sweep
// Post-reset clear sweep: walks the address range 0..DEPTH-1 once, one
// word per cycle, then stops until the next reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   o_addr     : address being cleared this cycle
//   o_we       : clear write strobe (high for exactly DEPTH cycles)
//   o_last     : high on the cycle that clears DEPTH-1
//   o_done     : sweep finished
module memory_clr_sweep
    import memory_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_last,
    output logic              o_done
);

    // Terminal count compared at ADDR_W bits.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;
    logic              w_at_last;

    assign w_at_last = (r_cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_at_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_addr = r_cnt;
    assign o_we   = !r_done;
    assign o_last = !r_done && w_at_last;
    assign o_done = r_done;

endmodule

// File: rtl/memory_clr.sv
// memory_clr
// Single-port synchronous memory with byte-lane writes, valid/ready
// request port, registered read response and a hardware clear sweep that
// fills every word with CLEAR_VAL after reset. The array is not reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : request present          req_ready : request accepted this cycle
//   req_we     : 1 = write, 0 = read      req_addr  : word address
//   req_wdata  : write data               req_be    : lane write enables
//   rsp_valid  : one-cycle read response  rsp_rdata : read data (held otherwise)
//   init_done  : clear sweep finished
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | sweep writing CLEAR_VAL to every word, requests ignored
// READY | requests accepted every cycle, left only through reset
module memory_clr
    import memory_pkg::*;
#(
    parameter int                   DATA_W    = 8,
    parameter int                   LANE_W    = 8,
    parameter int                   DEPTH     = 256,
    parameter int                   ADDR_W    = 8,
    parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/LANE_W-1:0]   req_be,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       init_done
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic              r_req_ready;
    logic              r_init_done;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_sweep_we;
    logic              w_sweep_last;
    logic              w_sweep_done;
    logic              w_in_range;
    logic              w_accept;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    memory_clr_sweep #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_addr (w_sweep_addr),
        .o_we   (w_sweep_we),
        .o_last (w_sweep_last),
        .o_done (w_sweep_done)
    );

    assign w_in_range = ({1'b0, req_addr} < DEPTH_X);
    assign w_accept   = req_valid && r_req_ready && w_sweep_done;
    // Out-of-range writes are accepted but never reach the array.
    assign w_wr_fire  = w_accept && req_we && w_in_range;
    assign w_rd_fire  = w_accept && !req_we;
    assign w_old      = r_mem[req_addr];
    assign w_merged   = DATA_W'(lane_merge(MAX_DATA_W'(w_old),
                                           MAX_DATA_W'(req_wdata),
                                           MAX_LANES'(req_be),
                                           LANE_W));

    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= CLEAR_VAL;
        end else if (w_wr_fire) begin
            r_mem[req_addr] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_req_ready <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_rsp_valid <= 1'b0;
                    if (w_sweep_last) begin
                        r_state     <= READY;
                        r_req_ready <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_rsp_valid <= w_rd_fire;
                    if (w_rd_fire) begin
                        r_rsp_rdata <= w_in_range ? w_old : '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign init_done = r_init_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_memory_clr.sv
module tb_memory_clr;

    localparam int          DEPTH = 200;
    localparam logic [31:0] CV    = 32'h5A5A_0F0F;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] exp_q [$];
    int          due_q [$];

    memory_clr #(
        .DATA_W    (32),
        .LANE_W    (8),
        .DEPTH     (DEPTH),
        .ADDR_W    (8),
        .CLEAR_VAL (CV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response is matched against the oldest expected read.
    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_rsp: none at cycle %0d, required data %h", due_q[0], exp_q[0]);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (rsp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got data %h at cycle %0d, required none", rsp_rdata, cyc);
            end else begin
                logic [31:0] e;
                int          d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                if (rsp_rdata !== e || d != cyc) begin
                    n_err++;
                    $display("FAIL rsp_data: got %h at cycle %0d, required %h at cycle %0d", rsp_rdata, cyc, e, d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0; req_be = '0;
        exp_q.push_back(e);
        due_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_we = 1'b0;
        end
    endtask

    // Counts rising edges from reset release until init_done; a garbage
    // write is held on the request port throughout and must be ignored.
    task automatic wait_init(input string tag);
        int n;
        bit early;
        n = 0;
        early = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05;
        req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        while (n < DEPTH + 20) begin
            @(posedge clk); #1;
            n++;
            if (init_done) break;
            if (req_ready) early = 1'b1;
        end
        req_valid = 1'b0;
        chk({tag, "_sweep_cycles"}, 32'(n), 32'(DEPTH));
        chk({tag, "_ready_early"}, 32'(early), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        wait_init("init1");
        rd(8'h00, CV);
        rd(8'h7F, CV);
        rd(8'hC7, CV);
        rd(8'h05, CV);
        idle(1);

        wr(8'h10, 32'h0000_00A5, 4'hF);
        rd(8'h10, 32'h0000_00A5);
        idle(1);

        wr(8'h20, 32'h1122_3344, 4'b1111);
        wr(8'h20, 32'hAABB_CCDD, 4'b0101);
        rd(8'h20, 32'h11BB_33DD);
        wr(8'h20, 32'hDEAD_BEEF, 4'b0000);
        rd(8'h20, 32'h11BB_33DD);
        wr(8'h21, 32'h1234_5678, 4'b1010);
        rd(8'h21, 32'h125A_560F);
        idle(1);

        wr(8'h01, 32'h0000_0001, 4'hF);
        wr(8'h02, 32'h0000_0002, 4'hF);
        wr(8'h03, 32'h0000_0003, 4'hF);
        rd(8'h01, 32'h0000_0001);
        rd(8'h02, 32'h0000_0002);
        rd(8'h03, 32'h0000_0003);
        idle(3);
        @(negedge clk);
        chk("hold_rdata", rsp_rdata, 32'h0000_0003);
        chk("hold_valid", 32'(rsp_valid), 32'd0);

        wr(8'hC8, 32'h0000_0055, 4'hF);
        rd(8'hC8, 32'h0000_0000);
        rd(8'h00, CV);
        rd(8'hC7, CV);
        rd(8'hFF, 32'h0000_0000);
        idle(1);

        wr(8'h00, 32'hFFFF_FFFF, 4'hF);
        wr(8'h40, 32'hFFFF_FFFF, 4'hF);
        wr(8'hC7, 32'hFFFF_FFFF, 4'hF);
        rd(8'h40, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pending_valid", 32'(rsp_valid), 32'd1);
        chk("pending_rdata", rsp_rdata, 32'hFFFF_FFFF);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        due_q.delete();
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midop_rsp_rdata", rsp_rdata, 32'd0);
        chk("midop_init_done", 32'(init_done), 32'd0);
        chk("midop_req_ready", 32'(req_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("sweep100_init_done", 32'(init_done), 32'd0);
        chk("sweep100_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midsweep_init_done", 32'(init_done), 32'd0);
        wait_init("init2");
        rd(8'h00, CV);
        rd(8'h40, CV);
        rd(8'hC7, CV);
        rd(8'h10, CV);
        idle(4);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_clr.md
Name: memory_clr

Overview:
- Parametrised single-port synchronous memory; the next generation of the team's plain 8x256 array.
- Adds configurable width and depth, byte-lane write enables, a valid/ready request port and a registered read with response valid.
- Adds a hardware clear sweep after reset, so the array holds a defined value without relying on simulator or FPGA init.
- Sits beneath formal/top-level harnesses as the storage UUT.

Parameters:
- DATA_W, 8, data word width in bits; must be a multiple of LANE_W.
- LANE_W, 8, byte-enable granularity in bits.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_W, 8, address width; DEPTH <= 2**ADDR_W.
- CLEAR_VAL, 0, DATA_W-bit value written to every word during the clear sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/LANE_W  lane write enables; bit i covers bits [i*LANE_W +: LANE_W].
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read.
- rsp_rdata  out  DATA_W  read data.
- init_done  out  1  clear sweep finished.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, state=CLEAR, sweep counter=0. The array itself is not reset.
- State CLEAR:
  - Each cycle writes CLEAR_VAL to mem[cnt] and increments cnt.
  - On the cycle that writes DEPTH-1, the next state is READY.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts.
  - req_ready=0 throughout; req_valid is ignored and may stay high.
- State READY:
  - req_ready=1 and init_done=1 continuously; READY is left only by reset.
- Transfer: a request is accepted when req_valid and req_ready are both 1 at a posedge.
- Write:
  - For each i with req_be[i]=1, the lane is updated at that posedge; lanes with be=0 keep their old value.
  - be all-zero is a no-op that is still accepted.
  - Writes produce no response.
- Read:
  - Accepted at edge N; rsp_valid=1 and rsp_rdata=mem[addr] during cycle N+1.
  - Back-to-back reads give back-to-back responses. There is no backpressure on the response.
- rsp_rdata holds its last value when rsp_valid=0.
- A read in the cycle after a write to the same address returns the new data.
- Out of range (req_addr >= DEPTH):
  - A write is accepted and dropped.
  - A read is accepted and answered with rsp_rdata=0.
- Reset mid-sweep or mid-operation:
  - All outputs return to their reset values immediately (async).
  - Any pending rsp_valid is cancelled.
  - The sweep restarts from address 0 after rst_n deasserts.
- Width rules: cnt is ADDR_W bits; the comparison against DEPTH-1 is done at ADDR_W bits.

Decomposition:
- Shared package memory_pkg:
  - state enum {CLEAR, READY}.
  - localparam LANES = DATA_W/LANE_W.
  - Function lane_merge(old, new, be) returning the masked word.
- One natural sub-module: memory_clr_sweep (counter plus done flag, outputs sweep address, write strobe and done). The array and response register stay in memory_clr.

Test Plan:
- Reset, then DEPTH=256 idle cycles -> init_done rises exactly 256 cycles after rst_n deasserts; req_ready=0 before that; reads of addr 0, 0x7F and 0xFF all return CLEAR_VAL=0.
- Write 0xA5 to addr 0x10 with be=1, then read 0x10 on the next cycle -> rsp_valid=1 one cycle after acceptance, rdata=0xA5.
- DATA_W=32, LANE_W=8:
  - Write 0x11223344 be=4'b1111, then 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD.
  - A write with be=0 leaves the word unchanged.
- Reads of 0x01, 0x02, 0x03 on three consecutive cycles after prior writes 0x01, 0x02, 0x03 -> three consecutive rsp_valid pulses with data 0x01, 0x02, 0x03; rsp_rdata holds 0x03 afterwards.
- DEPTH=200, ADDR_W=8: write 0x55 to addr 0xC8 -> no word changes; read 0xC8 -> rsp_valid=1, rdata=0.
- Assert rst_n=0 at sweep count 100, release, after prior writes of 0xFF -> init_done=0 immediately; sweep restarts and takes a full DEPTH cycles; every word reads CLEAR_VAL.
